vend_multi: RTL and testbench

VEND_MULTI -- requirements
Module: vend_multi

---
 rtl/vend_pkg.sv | 36 +++
 rtl/vend_stock.sv | 41 ++++
 rtl/vend_multi.sv | 267 ++++++++++++++++++++++++++
 tb/tb_vend_multi.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vend_pkg
// Description : Shared types and helpers for the multi-product vending
//               controller: FSM state encoding, coin code constants and the
//               greedy change-coin selector.
// Revision    : 1.0 - initial release
// ============================================================================
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_VEND   = 2'd2,
        ST_CHANGE = 2'd3
    } state_t;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_1    = 2'b01;
    localparam logic [1:0] COIN_2    = 2'b10;
    localparam logic [1:0] COIN_3    = 2'b11;

    // Largest coin whose value fits in the remaining credit, tried from the
    // biggest denomination down. Returns COIN_NONE when nothing fits.
    function automatic logic [1:0] greedy_coin(input logic [31:0] credit,
                                               input logic [31:0] v1,
                                               input logic [31:0] v2,
                                               input logic [31:0] v3);
        if (credit >= v3)      return COIN_3;
        else if (credit >= v2) return COIN_2;
        else if (credit >= v1) return COIN_1;
        else                   return COIN_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vend_stock.sv
`default_nettype none
// ============================================================================
// Module      : vend_stock
// Description : Per-product 4-bit stock counters with reset/restock load,
//               guarded decrement and sold-out flags.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_dec, i_dec_id - decrement stock of product i_dec_id
//               i_restock       - reload every counter with STOCK_INIT
//               o_sold_out      - bit i set while stock i is zero
// Revision    : 1.0 - initial release
// ============================================================================
module vend_stock #(
    parameter int N_PROD     = 4,
    parameter int IDW        = 2,
    parameter int STOCK_INIT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_dec,
    input  logic [IDW-1:0]    i_dec_id,
    input  logic              i_restock,
    output logic [N_PROD-1:0] o_sold_out
);

    for (genvar i = 0; i < N_PROD; i++) begin : g_stock
        logic [3:0] r_cnt;

        always_ff @(posedge clk) begin
            if (rst || i_restock) begin
                r_cnt <= 4'(STOCK_INIT);
            end else if (i_dec && (i_dec_id == IDW'(i)) && (r_cnt != 4'd0)) begin
                // Zero guard keeps the counter from wrapping to 15.
                r_cnt <= r_cnt - 4'd1;
            end
        end

        assign o_sold_out[i] = (r_cnt == 4'd0);
    end

endmodule
`default_nettype wire

// File: rtl/vend_multi.sv
`default_nettype none
// ============================================================================
// Module      : vend_multi
// Description : Multi-product vending controller. Accepts coins up to a
//               credit ceiling, vends a selected product when credit and stock
//               allow, and pays change one greedy coin per cycle.
// Ports       : clk, reset            - clock, synchronous active-high reset
//               coin                  - inserted coin code (00 = none)
//               sel_valid, sel_id     - product selection
//               cancel, restock       - refund request, stock refill
//               credit                - current credit
//               vend_valid, vend_id   - dispense pulse and product
//               chg_coin              - change coin paid this cycle
//               coin_rej, sel_err     - refusal pulses
//               sold_out, busy        - per-product empty flags, VEND/CHANGE
// Revision    : 1.0 - initial release
// ============================================================================
module vend_multi
    import vend_pkg::*;
#(
    parameter int                     N_PROD     = 4,
    parameter int                     CW         = 8,
    parameter int                     COIN1      = 5,
    parameter int                     COIN2      = 10,
    parameter int                     COIN3      = 25,
    parameter logic [N_PROD*CW-1:0]   PRICES     = {8'd50, 8'd40, 8'd25, 8'd15},
    parameter int                     MAX_CREDIT = 95,
    parameter int                     STOCK_INIT = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 coin,
    input  logic                       sel_valid,
    input  logic [$clog2(N_PROD)-1:0]  sel_id,
    input  logic                       cancel,
    input  logic                       restock,
    output logic [CW-1:0]              credit,
    output logic                       vend_valid,
    output logic [$clog2(N_PROD)-1:0]  vend_id,
    output logic [1:0]                 chg_coin,
    output logic                       coin_rej,
    output logic                       sel_err,
    output logic [N_PROD-1:0]          sold_out,
    output logic                       busy
);

    localparam int IDW = $clog2(N_PROD);

    localparam logic [CW-1:0] c_COIN1_V = CW'(COIN1);
    localparam logic [CW-1:0] c_COIN2_V = CW'(COIN2);
    localparam logic [CW-1:0] c_COIN3_V = CW'(COIN3);

    function automatic bit prices_ok();
        for (int i = 0; i < N_PROD; i++) begin
            if ((int'(PRICES[i*CW +: CW]) % COIN1) != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    localparam bit c_PARAMS_OK = (N_PROD >= 2) && (N_PROD <= 8) && (COIN1 > 0) &&
                                 (COIN2 % COIN1 == 0) && (COIN3 % COIN1 == 0) &&
                                 (MAX_CREDIT % COIN1 == 0) &&
                                 (MAX_CREDIT < (2 ** CW)) && prices_ok();

    if (!c_PARAMS_OK) begin : g_param_check
        $error("vend_multi: illegal parameter combination");
    end

    // ------------------------------------------------------------------
    // Registers and next-state wires
    // ------------------------------------------------------------------
    state_t            r_state, w_state_nxt;
    logic [CW-1:0]     r_credit, w_credit_nxt;
    logic [IDW-1:0]    r_sel, w_sel_nxt;
    logic              r_vend_valid, w_vend_valid_nxt;
    logic [IDW-1:0]    r_vend_id, w_vend_id_nxt;
    logic [1:0]        r_chg_coin, w_chg_coin_nxt;
    logic              r_coin_rej, w_coin_rej_nxt;
    logic              r_sel_err, w_sel_err_nxt;
    logic              w_dec, w_restock;
    logic [N_PROD-1:0] w_sold_out;

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    logic [CW-1:0] w_coin_val;
    logic [CW:0]   w_credit_sum;
    logic          w_coin_in;
    logic          w_coin_ok;
    logic [CW-1:0] w_req_price, w_sel_price;
    logic          w_req_in_range, w_req_stock_ok, w_req_ok;
    logic [CW-1:0] w_credit_after_vend;
    logic [1:0]    w_chg_code;
    logic [CW-1:0] w_chg_val;

    always_comb begin
        w_coin_val = '0;
        case (coin)
            COIN_1:  w_coin_val = c_COIN1_V;
            COIN_2:  w_coin_val = c_COIN2_V;
            COIN_3:  w_coin_val = c_COIN3_V;
            default: w_coin_val = '0;
        endcase
    end

    // One extra bit so a coin pushing past 2**CW is still seen as over the ceiling.
    assign w_credit_sum = {1'b0, r_credit} + {1'b0, w_coin_val};
    assign w_coin_in    = (coin != COIN_NONE);
    assign w_coin_ok    = w_coin_in && (w_credit_sum <= (CW+1)'(MAX_CREDIT));

    // Loop decode rather than a variable part-select so an id beyond N_PROD
    // (non power-of-two N_PROD) never indexes outside PRICES.
    always_comb begin
        w_req_price    = '0;
        w_req_in_range = 1'b0;
        w_req_stock_ok = 1'b0;
        w_sel_price    = '0;
        for (int i = 0; i < N_PROD; i++) begin
            if (sel_id == IDW'(i)) begin
                w_req_price    = PRICES[i*CW +: CW];
                w_req_in_range = 1'b1;
                w_req_stock_ok = !w_sold_out[i];
            end
            if (r_sel == IDW'(i)) begin
                w_sel_price = PRICES[i*CW +: CW];
            end
        end
    end

    assign w_req_ok = w_req_in_range && w_req_stock_ok && (r_credit >= w_req_price);

    // Credit was checked against this price on selection and cannot change
    // before VEND, so the subtraction never goes negative.
    assign w_credit_after_vend = r_credit - w_sel_price;

    assign w_chg_code = greedy_coin(32'(r_credit), 32'(COIN1), 32'(COIN2), 32'(COIN3));

    always_comb begin
        w_chg_val = '0;
        case (w_chg_code)
            COIN_1:  w_chg_val = c_COIN1_V;
            COIN_2:  w_chg_val = c_COIN2_V;
            COIN_3:  w_chg_val = c_COIN3_V;
            default: w_chg_val = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_credit     <= '0;
            r_sel        <= '0;
            r_vend_valid <= 1'b0;
            r_vend_id    <= '0;
            r_chg_coin   <= COIN_NONE;
            r_coin_rej   <= 1'b0;
            r_sel_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_credit     <= w_credit_nxt;
            r_sel        <= w_sel_nxt;
            r_vend_valid <= w_vend_valid_nxt;
            r_vend_id    <= w_vend_id_nxt;
            r_chg_coin   <= w_chg_coin_nxt;
            r_coin_rej   <= w_coin_rej_nxt;
            r_sel_err    <= w_sel_err_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!sel_valid && w_coin_ok) w_state_nxt = ST_CREDIT;
            end
            ST_CREDIT: begin
                if (cancel)                      w_state_nxt = ST_CHANGE;
                else if (sel_valid && w_req_ok)  w_state_nxt = ST_VEND;
            end
            ST_VEND: begin
                w_state_nxt = (w_credit_after_vend != '0) ? ST_CHANGE : ST_IDLE;
            end
            ST_CHANGE: begin
                // COIN_NONE cannot occur with legal parameters; it only
                // prevents a stuck state if credit were ever not payable.
                if ((w_chg_code == COIN_NONE) || (r_credit == w_chg_val))
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_credit_nxt     = r_credit;
        w_sel_nxt        = r_sel;
        w_vend_valid_nxt = 1'b0;
        w_vend_id_nxt    = r_vend_id;
        w_chg_coin_nxt   = COIN_NONE;
        w_coin_rej_nxt   = 1'b0;
        w_sel_err_nxt    = 1'b0;
        w_dec            = 1'b0;
        w_restock        = 1'b0;
        case (r_state)
            ST_IDLE, ST_CREDIT: begin
                w_restock = (r_state == ST_IDLE) && restock;
                if ((r_state == ST_CREDIT) && cancel) begin
                    w_coin_rej_nxt = w_coin_in;
                end else if (sel_valid) begin
                    w_coin_rej_nxt = w_coin_in;
                    if ((r_state == ST_CREDIT) && w_req_ok) w_sel_nxt     = sel_id;
                    else                                    w_sel_err_nxt = 1'b1;
                end else if (w_coin_in) begin
                    if (w_coin_ok) w_credit_nxt   = w_credit_sum[CW-1:0];
                    else           w_coin_rej_nxt = 1'b1;
                end
            end
            ST_VEND: begin
                w_vend_valid_nxt = 1'b1;
                w_vend_id_nxt    = r_sel;
                w_credit_nxt     = w_credit_after_vend;
                w_dec            = 1'b1;
                w_coin_rej_nxt   = w_coin_in;
                w_sel_err_nxt    = sel_valid;
            end
            ST_CHANGE: begin
                w_chg_coin_nxt = w_chg_code;
                w_credit_nxt   = r_credit - w_chg_val;
                w_coin_rej_nxt = w_coin_in;
                w_sel_err_nxt  = sel_valid;
            end
            default: ;
        endcase
    end

    vend_stock #(
        .N_PROD     (N_PROD),
        .IDW        (IDW),
        .STOCK_INIT (STOCK_INIT)
    ) u_stock (
        .clk        (clk),
        .rst        (reset),
        .i_dec      (w_dec),
        .i_dec_id   (r_sel),
        .i_restock  (w_restock),
        .o_sold_out (w_sold_out)
    );

    assign credit     = r_credit;
    assign vend_valid = r_vend_valid;
    assign vend_id    = r_vend_id;
    assign chg_coin   = r_chg_coin;
    assign coin_rej   = r_coin_rej;
    assign sel_err    = r_sel_err;
    assign sold_out   = w_sold_out;
    assign busy       = (r_state == ST_VEND) || (r_state == ST_CHANGE);

endmodule
`default_nettype wire

// File: tb/tb_vend_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_vend_multi
// Description : Directed, table-driven bench for vend_multi with default
//               parameters (prices p0=15 p1=25 p2=40 p3=50, coins 5/10/25,
//               ceiling 95, stock 2). Each table row is one clock: inputs
//               applied before the edge, outputs compared just after it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vend_multi;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] coin;
    logic       sel_valid;
    logic [1:0] sel_id;
    logic       cancel;
    logic       restock;
    logic [7:0] credit;
    logic       vend_valid;
    logic [1:0] vend_id;
    logic [1:0] chg_coin;
    logic       coin_rej;
    logic       sel_err;
    logic [3:0] sold_out;
    logic       busy;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    vend_multi dut (
        .clk        (clk),
        .reset      (reset),
        .coin       (coin),
        .sel_valid  (sel_valid),
        .sel_id     (sel_id),
        .cancel     (cancel),
        .restock    (restock),
        .credit     (credit),
        .vend_valid (vend_valid),
        .vend_id    (vend_id),
        .chg_coin   (chg_coin),
        .coin_rej   (coin_rej),
        .sel_err    (sel_err),
        .sold_out   (sold_out),
        .busy       (busy)
    );

    typedef struct {
        logic [1:0] coin;
        logic       sv;
        logic [1:0] sid;
        logic       cancel;
        logic       restock;
        int         credit;
        logic       vv;
        logic [1:0] vid;
        logic [1:0] chg;
        logic       rej;
        logic       serr;
        logic       busy;
        logic [3:0] sold;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [1:0] c, input logic sv, input logic [1:0] sid,
                                input logic can, input logic rs, input int cr,
                                input logic vv, input logic [1:0] vid, input logic [1:0] chg,
                                input logic rej, input logic serr, input logic bz,
                                input logic [3:0] sold);
        vec_t v;
        v.coin = c; v.sv = sv; v.sid = sid; v.cancel = can; v.restock = rs;
        v.credit = cr; v.vv = vv; v.vid = vid; v.chg = chg;
        v.rej = rej; v.serr = serr; v.busy = bz; v.sold = sold;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s (step %0d): got %0d, expected %0d", name, idx, act, exp);
    endtask

    task automatic drive(input logic [1:0] c, input logic sv, input logic [1:0] sid,
                         input logic can, input logic rs);
        coin = c; sel_valid = sv; sel_id = sid; cancel = can; restock = rs;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input int idx, input vec_t v);
        chk("credit",     idx, int'(credit),     v.credit);
        chk("vend_valid", idx, int'(vend_valid), int'(v.vv));
        if (v.vv) chk("vend_id", idx, int'(vend_id), int'(v.vid));
        chk("chg_coin",   idx, int'(chg_coin),   int'(v.chg));
        chk("coin_rej",   idx, int'(coin_rej),   int'(v.rej));
        chk("sel_err",    idx, int'(sel_err),    int'(v.serr));
        chk("busy",       idx, int'(busy),       int'(v.busy));
        chk("sold_out",   idx, int'(sold_out),   int'(v.sold));
    endtask

    initial begin
        //                coin  sv  sid  can rs  cred vv vid  chg   rej se bz sold
        // coins 10,10 then buy p0 (15): change 5
        vecs.push_back(mk(2'b10,0,2'd0,0,0, 10, 0,2'd0,2'b00,0,0,0,4'b0000));
        vecs.push_back(mk(2'b10,0,2'd0,0,0, 20, 0,2'd0,2'b00,0,0,0,4'b0000));
        vecs.push_back(mk(2'b00,1,2'd0,0,0, 20, 0,2'd0,2'b00,0,0,1,4'b0000));
        vecs.push_back(mk(2'b00,0,2'd0,0,0,  5, 1,2'd0,2'b00,0,0,1,4'b0000));
        vecs.push_back(mk(2'b00,0,2'd0,0,0,  0, 0,2'd0,2'b01,0,0,0,4'b0000));
        vecs.push_back(mk(2'b00,0,2'd0,0,0,  0, 0,2'd0,2'b00,0,0,0,4'b0000));
        // four quarters: fourth rejected, cancel pays 25,25,25
        vecs.push_back(mk(2'b11,0,2'd0,0,0, 25, 0,2'd0,2'b00,0,0,0,4'b0000));
        vecs.push_back(mk(2'b11,0,2'd0,0,0, 50, 0,2'd0,2'b00,0,0,0,4'b0000));
        vecs.push_back(mk(2'b11,0,2'd0,0,0, 75, 0,2'd0,2'b00,0,0,0,4'b0000));
        vecs.push_back(mk(2'b11,0,2'd0,0,0, 75, 0,2'd0,2'b00,1,0,0,4'b0000));
        vecs.push_back(mk(2'b00,0,2'd0,1,0, 75, 0,2'd0,2'b00,0,0,1,4'b0000));
        vecs.push_back(mk(2'b00,0,2'd0,0,0, 50, 0,2'd0,2'b11,0,0,1,4'b0000));
        vecs.push_back(mk(2'b00,0,2'd0,0,0, 25, 0,2'd0,2'b11,0,0,1,4'b0000));
        vecs.push_back(mk(2'b00,0,2'd0,0,0,  0, 0,2'd0,2'b11,0,0,0,4'b0000));
        vecs.push_back(mk(2'b00,0,2'd0,0,0,  0, 0,2'd0,2'b00,0,0,0,4'b0000));
        // credit 25, select p2 (40): refused, stays CREDIT; refund
        vecs.push_back(mk(2'b11,0,2'd0,0,0, 25, 0,2'd0,2'b00,0,0,0,4'b0000));
        vecs.push_back(mk(2'b00,1,2'd2,0,0, 25, 0,2'd0,2'b00,0,1,0,4'b0000));
        vecs.push_back(mk(2'b00,0,2'd0,1,0, 25, 0,2'd0,2'b00,0,0,1,4'b0000));
        vecs.push_back(mk(2'b00,0,2'd0,0,0,  0, 0,2'd0,2'b11,0,0,0,4'b0000));
        // credit 15, cancel with coin 10: coin rejected, change 10 then 5
        vecs.push_back(mk(2'b10,0,2'd0,0,0, 10, 0,2'd0,2'b00,0,0,0,4'b0000));
        vecs.push_back(mk(2'b01,0,2'd0,0,0, 15, 0,2'd0,2'b00,0,0,0,4'b0000));
        vecs.push_back(mk(2'b10,0,2'd0,1,0, 15, 0,2'd0,2'b00,1,0,1,4'b0000));
        vecs.push_back(mk(2'b00,0,2'd0,0,0,  5, 0,2'd0,2'b10,0,0,1,4'b0000));
        vecs.push_back(mk(2'b00,0,2'd0,0,0,  0, 0,2'd0,2'b01,0,0,0,4'b0000));
        // two exact-price vends of p1 (25) empty it; third select refused
        vecs.push_back(mk(2'b11,0,2'd0,0,0, 25, 0,2'd0,2'b00,0,0,0,4'b0000));
        vecs.push_back(mk(2'b00,1,2'd1,0,0, 25, 0,2'd0,2'b00,0,0,1,4'b0000));
        vecs.push_back(mk(2'b00,0,2'd0,0,0,  0, 1,2'd1,2'b00,0,0,0,4'b0000));
        vecs.push_back(mk(2'b11,0,2'd0,0,0, 25, 0,2'd0,2'b00,0,0,0,4'b0000));
        vecs.push_back(mk(2'b00,1,2'd1,0,0, 25, 0,2'd0,2'b00,0,0,1,4'b0000));
        vecs.push_back(mk(2'b00,0,2'd0,0,0,  0, 1,2'd1,2'b00,0,0,0,4'b0010));
        vecs.push_back(mk(2'b11,0,2'd0,0,0, 25, 0,2'd0,2'b00,0,0,0,4'b0010));
        vecs.push_back(mk(2'b00,1,2'd1,0,0, 25, 0,2'd0,2'b00,0,1,0,4'b0010));
        // restock outside IDLE is ignored
        vecs.push_back(mk(2'b00,0,2'd0,0,1, 25, 0,2'd0,2'b00,0,0,0,4'b0010));
        vecs.push_back(mk(2'b00,0,2'd0,1,0, 25, 0,2'd0,2'b00,0,0,1,4'b0010));
        vecs.push_back(mk(2'b00,0,2'd0,0,0,  0, 0,2'd0,2'b11,0,0,0,4'b0010));
        // restock in IDLE refills
        vecs.push_back(mk(2'b00,0,2'd0,0,1,  0, 0,2'd0,2'b00,0,0,0,4'b0000));
        // select in IDLE: sel_err, simultaneous coin rejected
        vecs.push_back(mk(2'b01,1,2'd0,0,0,  0, 0,2'd0,2'b00,1,1,0,4'b0000));
        // fill to exactly 95, then a nickel is refused
        vecs.push_back(mk(2'b11,0,2'd0,0,0, 25, 0,2'd0,2'b00,0,0,0,4'b0000));
        vecs.push_back(mk(2'b11,0,2'd0,0,0, 50, 0,2'd0,2'b00,0,0,0,4'b0000));
        vecs.push_back(mk(2'b11,0,2'd0,0,0, 75, 0,2'd0,2'b00,0,0,0,4'b0000));
        vecs.push_back(mk(2'b10,0,2'd0,0,0, 85, 0,2'd0,2'b00,0,0,0,4'b0000));
        vecs.push_back(mk(2'b10,0,2'd0,0,0, 95, 0,2'd0,2'b00,0,0,0,4'b0000));
        vecs.push_back(mk(2'b01,0,2'd0,0,0, 95, 0,2'd0,2'b00,1,0,0,4'b0000));
        // buy p3 (50) with a coin in the same cycle; coin+select during VEND
        vecs.push_back(mk(2'b01,1,2'd3,0,0, 95, 0,2'd0,2'b00,1,0,1,4'b0000));
        vecs.push_back(mk(2'b10,1,2'd0,0,0, 45, 1,2'd3,2'b00,1,1,1,4'b0000));
        // change 45 = 25+10+10; cancel during CHANGE ignored
        vecs.push_back(mk(2'b00,0,2'd0,1,0, 20, 0,2'd0,2'b11,0,0,1,4'b0000));
        vecs.push_back(mk(2'b00,0,2'd0,0,0, 10, 0,2'd0,2'b10,0,0,1,4'b0000));
        vecs.push_back(mk(2'b00,0,2'd0,0,0,  0, 0,2'd0,2'b10,0,0,0,4'b0000));
        vecs.push_back(mk(2'b00,0,2'd0,0,0,  0, 0,2'd0,2'b00,0,0,0,4'b0000));

        // ---- reset state ----
        reset = 1'b1;
        drive(2'b00, 1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        chk("rst_credit",   0, int'(credit),     0);
        chk("rst_vend",     0, int'(vend_valid), 0);
        chk("rst_vend_id",  0, int'(vend_id),    0);
        chk("rst_chg",      0, int'(chg_coin),   0);
        chk("rst_rej",      0, int'(coin_rej),   0);
        chk("rst_serr",     0, int'(sel_err),    0);
        chk("rst_sold_out", 0, int'(sold_out),   0);
        chk("rst_busy",     0, int'(busy),       0);

        // ---- table ----
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].coin, vecs[i].sv, vecs[i].sid, vecs[i].cancel, vecs[i].restock);
            tick();
            check_all(i + 1, vecs[i]);
        end

        // ---- p3 has one left: empty it, then reset in CHANGE with credit 30 ----
        drive(2'b11, 1'b0, 2'd0, 1'b0, 1'b0); tick();
        drive(2'b11, 1'b0, 2'd0, 1'b0, 1'b0); tick();
        chk("seq_credit50", 100, int'(credit), 50);
        drive(2'b00, 1'b1, 2'd3, 1'b0, 1'b0); tick();
        drive(2'b00, 1'b0, 2'd0, 1'b0, 1'b0); tick();
        chk("seq_vend3",    101, int'(vend_valid), 1);
        chk("seq_vend3_id", 101, int'(vend_id),    3);
        chk("seq_sold3",    101, int'(sold_out),   8);
        chk("seq_idle_cr",  101, int'(credit),     0);
        drive(2'b11, 1'b0, 2'd0, 1'b0, 1'b0); tick();
        drive(2'b01, 1'b0, 2'd0, 1'b0, 1'b0); tick();
        drive(2'b00, 1'b0, 2'd0, 1'b1, 1'b0); tick();
        chk("seq_chg_busy", 102, int'(busy),   1);
        chk("seq_chg_cr",   102, int'(credit), 30);
        drive(2'b00, 1'b0, 2'd0, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_credit", 103, int'(credit),   0);
        chk("mid_rst_busy",   103, int'(busy),     0);
        chk("mid_rst_chg",    103, int'(chg_coin), 0);
        chk("mid_rst_sold",   103, int'(sold_out), 0);
        chk("mid_rst_vend",   103, int'(vend_valid), 0);
        // still idle next cycle: no change coin leaks out after reset
        tick();
        chk("post_rst_chg",   104, int'(chg_coin), 0);
        chk("post_rst_busy",  104, int'(busy),     0);
        // normal operation resumes
        drive(2'b01, 1'b0, 2'd0, 1'b0, 1'b0); tick();
        chk("post_rst_coin",  105, int'(credit),   5);
        drive(2'b00, 1'b0, 2'd0, 1'b0, 1'b0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
